// File: rtl/mips_run_pkg.sv
// Shared types for the MIPS run controller: sequencer states and the 2-bit status code.
package mips_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALT    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_t;

    localparam logic [1:0] STAT_IDLE    = 2'b00;
    localparam logic [1:0] STAT_RUN     = 2'b01;
    localparam logic [1:0] STAT_HALT    = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    function automatic logic [1:0] state_status(input run_state_t s);
        logic [1:0] st;
        st = STAT_IDLE;
        case (s)
            ST_RUN:     st = STAT_RUN;
            ST_HALT:    st = STAT_HALT;
            ST_TIMEOUT: st = STAT_TIMEOUT;
            default:    st = STAT_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mips_wtrace_buf.sv
// Circular buffer of the most recent data-memory writes with a saturating fill count.
// Read index 0 selects the newest entry; the read path is combinational.
module mips_wtrace_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_adr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W-1:0]             rd_adr,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     adr_mem  [DEPTH];
    logic [W-1:0]     data_mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr_reg;
    logic [IDX_W:0]   fill_reg;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            fill_reg   <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            fill_reg   <= '0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + IDX_W'(1);
            if (fill_reg != (IDX_W+1)'(DEPTH))
                fill_reg <= fill_reg + (IDX_W+1)'(1);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en && wr_ptr_reg == IDX_W'(gi)) begin
                adr_mem[gi]  <= wr_adr;
                data_mem[gi] <= wr_data;
            end
        end
    end

    // Newest entry sits one slot behind the write pointer; index counts backwards in time.
    assign rd_ptr   = wr_ptr_reg - IDX_W'(1) - rd_idx;
    assign rd_adr   = adr_mem[rd_ptr];
    assign rd_data  = data_mem[rd_ptr];
    assign rd_valid = ({1'b0, rd_idx} < fill_reg);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run sequencer for the single-cycle MIPS: timed CPU reset, run with halt/timeout detection,
// cycle and write counting. Define MIPS_RUN_WTRACE_EN to add the data-write trace buffer.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int CYC_W        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int HALT_REPEAT  = 4,
    parameter int MAX_CYCLES   = 312,
    parameter int TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              inst_adr,
    input  logic                           mem_write,
    input  logic [ADDR_W-1:0]              data_adr,
    input  logic [ADDR_W-1:0]              data_wr,
    output logic                           cpu_rst,
    output logic                           running,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [CYC_W-1:0]               cycle_cnt,
    output logic [CYC_W-1:0]               wr_cnt
`ifdef MIPS_RUN_WTRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [ADDR_W-1:0]              trace_adr,
    output logic [ADDR_W-1:0]              trace_data,
    output logic                           trace_valid
`endif
);
    localparam int RST_W  = $clog2(RESET_CYCLES + 1);
    localparam int SAME_W = $clog2(HALT_REPEAT);

    run_state_t        state_reg, state_next;
    logic [RST_W-1:0]  rst_cnt_reg;
    logic [CYC_W-1:0]  cycle_cnt_reg, wr_cnt_reg;
    logic [ADDR_W-1:0] prev_adr_reg;
    logic              prev_valid_reg;
    logic [SAME_W-1:0] same_cnt_reg;
    logic              cpu_rst_reg, running_reg, done_reg;
    logic [1:0]        status_reg;

    logic pc_match, halt_hit, timeout_hit, launch, in_run;

    assign in_run   = (state_reg == ST_RUN);
    assign pc_match = prev_valid_reg && (inst_adr == prev_adr_reg);
    // same_cnt counts matches, so HALT_REPEAT equal PCs end the run on the (HALT_REPEAT-1)th match.
    assign halt_hit    = pc_match && (same_cnt_reg == SAME_W'(HALT_REPEAT - 2));
    assign timeout_hit = (cycle_cnt_reg == CYC_W'(MAX_CYCLES - 1));
    assign launch      = start && (state_reg == ST_IDLE || state_reg == ST_HALT ||
                                   state_reg == ST_TIMEOUT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_RESET;
            ST_RESET:   if (rst_cnt_reg == '0) state_next = ST_RUN;
            ST_RUN: begin
                if (halt_hit)         state_next = ST_HALT;
                else if (timeout_hit) state_next = ST_TIMEOUT;
            end
            ST_HALT,
            ST_TIMEOUT: if (start) state_next = ST_RESET;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            rst_cnt_reg    <= '0;
            cycle_cnt_reg  <= '0;
            wr_cnt_reg     <= '0;
            prev_adr_reg   <= '0;
            prev_valid_reg <= 1'b0;
            same_cnt_reg   <= '0;
            cpu_rst_reg    <= 1'b1;
            running_reg    <= 1'b0;
            done_reg       <= 1'b0;
            status_reg     <= STAT_IDLE;
        end else begin
            state_reg   <= state_next;
            cpu_rst_reg <= (state_next != ST_RUN);
            running_reg <= (state_next == ST_RUN);
            done_reg    <= (state_next == ST_HALT) || (state_next == ST_TIMEOUT);
            status_reg  <= state_status(state_next);
            if (launch) begin
                rst_cnt_reg    <= RST_W'(RESET_CYCLES - 1);
                cycle_cnt_reg  <= '0;
                wr_cnt_reg     <= '0;
                prev_valid_reg <= 1'b0;
                same_cnt_reg   <= '0;
            end else if (state_reg == ST_RESET) begin
                if (rst_cnt_reg != '0)
                    rst_cnt_reg <= rst_cnt_reg - RST_W'(1);
            end else if (in_run) begin
                cycle_cnt_reg  <= cycle_cnt_reg + CYC_W'(1);
                if (mem_write && !(&wr_cnt_reg))
                    wr_cnt_reg <= wr_cnt_reg + CYC_W'(1);
                prev_adr_reg   <= inst_adr;
                prev_valid_reg <= 1'b1;
                same_cnt_reg   <= pc_match ? same_cnt_reg + SAME_W'(1) : '0;
            end
        end
    end

    assign cpu_rst   = cpu_rst_reg;
    assign running   = running_reg;
    assign done      = done_reg;
    assign status    = status_reg;
    assign cycle_cnt = cycle_cnt_reg;
    assign wr_cnt    = wr_cnt_reg;

`ifdef MIPS_RUN_WTRACE_EN
    mips_wtrace_buf #(
        .DEPTH (TRACE_DEPTH),
        .W     (ADDR_W)
    ) u_wtrace (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch),
        .wr_en    (in_run && mem_write),
        .wr_adr   (data_adr),
        .wr_data  (data_wr),
        .rd_idx   (trace_idx),
        .rd_adr   (trace_adr),
        .rd_data  (trace_data),
        .rd_valid (trace_valid)
    );
`else
    localparam int unused_trace_depth = TRACE_DEPTH;
    logic unused_data;
    assign unused_data = ^{data_adr, data_wr};
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed table, corner-case sequences and a
// randomized run checked cycle-by-cycle against a queue-based behavioural model.
module tb_mips_run_ctrl;
    localparam int ADDR_W = 32;
    localparam int CYC_W  = 16;
    localparam int RC     = 2;
    localparam int HR     = 4;
    localparam int MAXC   = 20;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] inst_adr, data_adr, data_wr;
    logic              mem_write;
    logic              cpu_rst, running, done;
    logic [1:0]        status;
    logic [CYC_W-1:0]  cycle_cnt, wr_cnt;
`ifdef MIPS_RUN_WTRACE_EN
    logic [2:0]        trace_idx;
    logic [ADDR_W-1:0] trace_adr, trace_data;
    logic              trace_valid;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .ADDR_W(ADDR_W), .CYC_W(CYC_W), .RESET_CYCLES(RC), .HALT_REPEAT(HR),
        .MAX_CYCLES(MAXC), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inst_adr(inst_adr), .mem_write(mem_write),
        .data_adr(data_adr), .data_wr(data_wr), .cpu_rst(cpu_rst), .running(running),
        .done(done), .status(status), .cycle_cnt(cycle_cnt), .wr_cnt(wr_cnt)
`ifdef MIPS_RUN_WTRACE_EN
        , .trace_idx(trace_idx), .trace_adr(trace_adr), .trace_data(trace_data),
        .trace_valid(trace_valid)
`endif
    );

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 reset, 2 run, 3 halt, 4 timeout
    int          m_phase;
    int          m_rst_left;
    int          m_cyc;
    int          m_wr;
    logic [31:0] m_pcs[$];
    logic [31:0] m_tadr[$];
    logic [31:0] m_tdat[$];

    task automatic model_reset();
        m_phase = 0; m_rst_left = 0; m_cyc = 0; m_wr = 0;
        m_pcs.delete(); m_tadr.delete(); m_tdat.delete();
    endtask

    task automatic model_edge(bit st, logic [31:0] pc, bit mw, logic [31:0] da, logic [31:0] dd);
        bit halted;
        case (m_phase)
            0, 3, 4: if (st) begin
                m_phase = 1; m_rst_left = RC; m_cyc = 0; m_wr = 0;
                m_pcs.delete(); m_tadr.delete(); m_tdat.delete();
            end
            1: begin
                m_rst_left--;
                if (m_rst_left == 0) m_phase = 2;
            end
            2: begin
                m_cyc++;
                m_pcs.push_back(pc);
                if (mw) begin
                    if (m_wr < (1 << CYC_W) - 1) m_wr++;
                    m_tadr.push_front(da);
                    m_tdat.push_front(dd);
                    if (m_tadr.size() > DEPTH) begin
                        void'(m_tadr.pop_back());
                        void'(m_tdat.pop_back());
                    end
                end
                halted = 1'b0;
                if (m_pcs.size() >= HR) begin
                    halted = 1'b1;
                    for (int i = 1; i < HR; i++)
                        if (m_pcs[m_pcs.size() - 1 - i] != m_pcs[m_pcs.size() - 1]) halted = 1'b0;
                end
                if (halted) m_phase = 3;
                else if (m_cyc == MAXC) m_phase = 4;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0] es;
        es = (m_phase <= 1) ? 2'b00 : 2'(m_phase - 1);
        chk("model.status", 64'(status), 64'(es));
        chk("model.cpu_rst", 64'(cpu_rst), 64'(m_phase != 2));
        chk("model.running", 64'(running), 64'(m_phase == 2));
        chk("model.done", 64'(done), 64'(m_phase >= 3));
        chk("model.cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
        chk("model.wr_cnt", 64'(wr_cnt), 64'(m_wr));
`ifdef MIPS_RUN_WTRACE_EN
        chk("model.trace_valid", 64'(trace_valid), 64'(int'(trace_idx) < m_tadr.size()));
        if (int'(trace_idx) < m_tadr.size()) begin
            chk("model.trace_adr", 64'(trace_adr), 64'(m_tadr[trace_idx]));
            chk("model.trace_data", 64'(trace_data), 64'(m_tdat[trace_idx]));
        end
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(bit st, logic [31:0] pc, bit mw, logic [31:0] da, logic [31:0] dd);
        start = st; inst_adr = pc; mem_write = mw; data_adr = da; data_wr = dd;
`ifdef MIPS_RUN_WTRACE_EN
        trace_idx = 3'($urandom_range(0, DEPTH - 1));
`endif
        @(posedge clk);
        model_edge(st, pc, mw, da, dd);
        #1;
        check_model();
    endtask

    task automatic idle_step(logic [31:0] pc);
        step(1'b0, pc, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic launch();
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < RC; i++) idle_step(32'h0);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("mid_rst.status", 64'(status), 64'(0));
        chk("mid_rst.cpu_rst", 64'(cpu_rst), 64'(1));
        chk("mid_rst.cycle_cnt", 64'(cycle_cnt), 64'(0));
        chk("mid_rst.wr_cnt", 64'(wr_cnt), 64'(0));
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          st;
        logic [31:0] pc;
        logic [1:0]  exp_status;
        bit          exp_cpu_rst;
        logic [15:0] exp_cyc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; inst_adr = '0; mem_write = 1'b0; data_adr = '0; data_wr = '0;
`ifdef MIPS_RUN_WTRACE_EN
        trace_idx = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cpu_rst", 64'(cpu_rst), 64'(1));
        chk("reset.running", 64'(running), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.status", 64'(status), 64'(0));
        chk("reset.cycle_cnt", 64'(cycle_cnt), 64'(0));
        chk("reset.wr_cnt", 64'(wr_cnt), 64'(0));
`ifdef MIPS_RUN_WTRACE_EN
        chk("reset.trace_valid", 64'(trace_valid), 64'(0));
`endif
        rst = 1'b1;

        // Stuck-PC halt: PCs 0x04..0x28 over ten RUN cycles, then 0x28 held.
        tbl[0] = '{1'b1, 32'h0, 2'b00, 1'b1, 16'd0};
        tbl[1] = '{1'b0, 32'h0, 2'b00, 1'b1, 16'd0};
        tbl[2] = '{1'b0, 32'h0, 2'b01, 1'b0, 16'd0};
        for (int k = 1; k <= 13; k++)
            tbl[2 + k] = '{1'b0, (k <= 10) ? 32'(4 * k) : 32'h28,
                           (k == 13) ? 2'b10 : 2'b01, (k == 13), 16'(k)};
        tbl[16] = '{1'b0, 32'h28, 2'b10, 1'b1, 16'd13};
        for (int r = 0; r < 17; r++) begin
            step(tbl[r].st, tbl[r].pc, 1'b0, 32'h0, 32'h0);
            chk($sformatf("tbl%0d.status", r), 64'(status), 64'(tbl[r].exp_status));
            chk($sformatf("tbl%0d.cpu_rst", r), 64'(cpu_rst), 64'(tbl[r].exp_cpu_rst));
            chk($sformatf("tbl%0d.cycle_cnt", r), 64'(cycle_cnt), 64'(tbl[r].exp_cyc));
            chk($sformatf("tbl%0d.wr_cnt", r), 64'(wr_cnt), 64'(0));
        end

        // Timeout after MAXC RUN cycles with an ever-changing PC.
        launch();
        for (int k = 1; k <= MAXC; k++) idle_step(32'h1000 + 32'(4 * k));
        chk("timeout.status", 64'(status), 64'(2'b11));
        chk("timeout.cycle_cnt", 64'(cycle_cnt), 64'(MAXC));
        chk("timeout.cpu_rst", 64'(cpu_rst), 64'(1));
        idle_step(32'h0);
        chk("timeout.frozen", 64'(cycle_cnt), 64'(MAXC));

        // Halt and timeout on the same cycle: halt wins.
        launch();
        for (int k = 1; k <= MAXC; k++)
            idle_step((k <= MAXC - HR) ? 32'h3000 + 32'(4 * k) : 32'h500);
        chk("both.status", 64'(status), 64'(2'b10));
        chk("both.cycle_cnt", 64'(cycle_cnt), 64'(MAXC));

        // 11 writes, then stall the PC to halt; start in RUN is ignored.
        launch();
        for (int k = 0; k < 11; k++)
            step(1'b0, 32'h2000 + 32'(4 * k), 1'b1, 32'h100 + 32'(4 * k), 32'(k));
        chk("wr11.wr_cnt", 64'(wr_cnt), 64'(11));
`ifdef MIPS_RUN_WTRACE_EN
        trace_idx = 3'd0; #1;
        chk("wr11.idx0_adr", 64'(trace_adr), 64'(32'h128));
        chk("wr11.idx0_data", 64'(trace_data), 64'(10));
        trace_idx = 3'd7; #1;
        chk("wr11.idx7_adr", 64'(trace_adr), 64'(32'h10C));
        chk("wr11.idx7_data", 64'(trace_data), 64'(3));
        for (int i = 0; i < DEPTH; i++) begin
            trace_idx = 3'(i); #1;
            chk($sformatf("wr11.valid%0d", i), 64'(trace_valid), 64'(1));
        end
`endif
        step(1'b1, 32'h4000, 1'b0, 32'h0, 32'h0);
        chk("start_in_run.running", 64'(running), 64'(1));
        chk("start_in_run.cycle_cnt", 64'(cycle_cnt), 64'(12));
        for (int k = 0; k < HR; k++) idle_step(32'h4004);
        chk("wr11.halt", 64'(status), 64'(2'b10));

        // Restart from HALT clears counters and trace; then 3 writes.
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("restart.cycle_cnt", 64'(cycle_cnt), 64'(0));
        chk("restart.wr_cnt", 64'(wr_cnt), 64'(0));
`ifdef MIPS_RUN_WTRACE_EN
        trace_idx = 3'd0; #1;
        chk("restart.trace_valid", 64'(trace_valid), 64'(0));
`endif
        for (int i = 0; i < RC; i++) idle_step(32'h0);
        for (int k = 0; k < 3; k++)
            step(1'b0, 32'h6000 + 32'(4 * k), 1'b1, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k));
        chk("wr3.wr_cnt", 64'(wr_cnt), 64'(3));
`ifdef MIPS_RUN_WTRACE_EN
        for (int i = 0; i < DEPTH; i++) begin
            trace_idx = 3'(i); #1;
            chk($sformatf("wr3.valid%0d", i), 64'(trace_valid), 64'(i < 3));
        end
`endif

        // Reset mid-run, then start gives exactly RC cycles of cpu_rst.
        idle_step(32'h7000);
        async_reset();
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < RC; i++) begin
            chk($sformatf("rerun.cpu_rst_hi%0d", i), 64'(cpu_rst), 64'(1));
            idle_step(32'h0);
        end
        chk("rerun.cpu_rst_lo", 64'(cpu_rst), 64'(0));

        // Randomized runs against the model.
        begin
            logic [31:0] pc;
            pc = 32'h0;
            for (int r = 0; r < 40; r++) begin
                launch();
                for (int c = 0; c < 28; c++) begin
                    if ($urandom_range(0, 1) == 0) pc = 32'(4 * $urandom_range(0, 3));
                    step($urandom_range(0, 7) == 0, pc, 1'($urandom_range(0, 1)),
                         $urandom, $urandom);
                    if ($urandom_range(0, 60) == 0) async_reset();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
